// File: rtl/interrupt_controller.sv
// Interrupt front end for the status counter: latches rising-edge requests, applies
// mask, global enable and fixed priority, grants on IF0 and presents the vector during IT0..IT2.
module interrupt_controller #(
  parameter int unsigned       N_IRQ      = 4,
  parameter int unsigned       ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] VEC_BASE   = 8'hF0,
  parameter int unsigned       VEC_STRIDE = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IRQ-1:0]  IRQ,
  input  logic              IF0,
  input  logic              IT0,
  input  logic              IT2,
  input  logic              IE_SET,
  input  logic              IE_CLR,
  input  logic              MASK_WE,
  input  logic [N_IRQ-1:0]  MASK_WD,
  output logic              ITA,
  output logic [ADDR_W-1:0] VECTOR,
  output logic              VEC_VALID,
  output logic [N_IRQ-1:0]  PEND,
  output logic              IE,
  output logic              SPURIOUS
);

  localparam int unsigned       ID_W        = $clog2(N_IRQ + 1);
  localparam logic [ADDR_W-1:0] VEC_DEFAULT = VEC_BASE + ADDR_W'(VEC_STRIDE * N_IRQ);

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [N_IRQ-1:0]  irq_q;
  logic [N_IRQ-1:0]  pend_q, pend_d;
  logic [N_IRQ-1:0]  mask_q, mask_d;
  logic              ie_q, ie_d;
  logic [ADDR_W-1:0] vector_q, vector_d;
  logic              vec_valid_q, vec_valid_d;
  logic              spurious_q, spurious_d;

  logic [N_IRQ-1:0]  rise_c, req_c, clr_c;
  logic [ID_W-1:0]   win_id_c;
  logic              ita_c, grant_c, spur_c;

  assign rise_c = IRQ & ~irq_q;
  assign req_c  = pend_q & mask_q;

  // Fixed priority: lowest pending, unmasked index wins.
  always_comb begin
    win_id_c = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (req_c[i]) win_id_c = ID_W'(i);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_c || spur_c) state_d = SERVE;
      SERVE:   if (IT2) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath-next logic
  always_comb begin
    ita_c       = IF0 & ie_q & (|req_c) & (state_q == IDLE);
    grant_c     = ita_c;
    spur_c      = IT0 & (state_q == IDLE) & ~grant_c;
    clr_c       = grant_c ? (N_IRQ'(1) << win_id_c) : '0;
    pend_d      = (pend_q & ~clr_c) | rise_c;
    mask_d      = MASK_WE ? MASK_WD : mask_q;
    vector_d    = vector_q;
    vec_valid_d = vec_valid_q;
    spurious_d  = 1'b0;
    ie_d        = ie_q;
    // Auto-clear at grant beats both software controls.
    if (grant_c)     ie_d = 1'b0;
    else if (IE_CLR) ie_d = 1'b0;
    else if (IE_SET) ie_d = 1'b1;
    if (grant_c) begin
      vector_d    = VEC_BASE + ADDR_W'(VEC_STRIDE * 32'(win_id_c));
      vec_valid_d = 1'b1;
    end else if (spur_c) begin
      vector_d    = VEC_DEFAULT;
      vec_valid_d = 1'b1;
      spurious_d  = 1'b1;
    end else if ((state_q == SERVE) && IT2) begin
      vec_valid_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q       <= '0;
      pend_q      <= '0;
      mask_q      <= '1;
      ie_q        <= 1'b0;
      vector_q    <= '0;
      vec_valid_q <= 1'b0;
      spurious_q  <= 1'b0;
    end else begin
      irq_q       <= IRQ;
      pend_q      <= pend_d;
      mask_q      <= mask_d;
      ie_q        <= ie_d;
      vector_q    <= vector_d;
      vec_valid_q <= vec_valid_d;
      spurious_q  <= spurious_d;
    end
  end

  assign ITA       = ita_c;
  assign VECTOR    = vector_q;
  assign VEC_VALID = vec_valid_q;
  assign PEND      = pend_q;
  assign IE        = ie_q;
  assign SPURIOUS  = spurious_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed vector table, hand sequences for the
// multi-cycle corners, then random stimulus against a behavioural model.
module tb_interrupt_controller;

  localparam int VB = 'hF0;
  localparam int VS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq, mask_wd, pend;
  logic       if0, it0, it2, ie_set, ie_clr, mask_we;
  logic       ita, vec_valid, ie, spurious;
  logic [7:0] vector;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;

  // Behavioural model state
  bit [3:0] m_prev, m_pend, m_mask;
  bit       m_ie, m_busy, m_spur;
  int       m_vec;

  interrupt_controller dut (
    .clk(clk), .reset(rst), .IRQ(irq), .IF0(if0), .IT0(it0), .IT2(it2),
    .IE_SET(ie_set), .IE_CLR(ie_clr), .MASK_WE(mask_we), .MASK_WD(mask_wd),
    .ITA(ita), .VECTOR(vector), .VEC_VALID(vec_valid), .PEND(pend), .IE(ie),
    .SPURIOUS(spurious)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] irq;
    logic       if0, it0, it2, ies;
    logic       e_ita;
    logic [3:0] e_pend;
    logic       e_ie, e_vv;
    logic [7:0] e_vec;
    logic       e_spur;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc_n, act, exp);
    end
  endtask

  function automatic bit model_ita();
    return if0 && m_ie && ((m_pend & m_mask) != 4'b0) && !m_busy;
  endfunction

  task automatic model_check();
    chk("ITA", 32'(ita), 32'(model_ita()));
    chk("PEND", 32'(pend), 32'(m_pend));
    chk("IE", 32'(ie), 32'(m_ie));
    chk("VEC_VALID", 32'(vec_valid), 32'(m_busy));
    chk("VECTOR", 32'(vector), 32'(m_vec));
    chk("SPURIOUS", 32'(spurious), 32'(m_spur));
  endtask

  // Spec rules applied at the clock edge using the currently driven inputs.
  task automatic model_edge();
    int win;
    bit grant, spur;
    if (rst) begin
      m_prev = '0; m_pend = '0; m_mask = 4'hF; m_ie = 0;
      m_busy = 0; m_spur = 0; m_vec = 0;
      return;
    end
    win = -1;
    for (int i = 3; i >= 0; i--) if (m_pend[i] && m_mask[i]) win = i;
    grant = model_ita();
    spur  = !grant && it0 && !m_busy;
    if (grant) m_pend[win] = 1'b0;
    m_pend = m_pend | (irq & ~m_prev);
    m_prev = irq;
    if (grant)       m_ie = 0;
    else if (ie_clr) m_ie = 0;
    else if (ie_set) m_ie = 1;
    if (mask_we) m_mask = mask_wd;
    m_spur = spur;
    if (grant) begin
      m_busy = 1; m_vec = (VB + win * VS) % 256;
    end else if (spur) begin
      m_busy = 1; m_vec = (VB + 4 * VS) % 256;
    end else if (m_busy && it2) begin
      m_busy = 0;
    end
  endtask

  task automatic drv(input logic [3:0] i_irq, input logic i_if0, input logic i_it0,
                     input logic i_it2, input logic i_ies, input logic i_iec,
                     input logic i_mwe, input logic [3:0] i_mwd, input logic i_rst,
                     input bit do_chk);
    irq = i_irq; if0 = i_if0; it0 = i_it0; it2 = i_it2; ie_set = i_ies;
    ie_clr = i_iec; mask_we = i_mwe; mask_wd = i_mwd; rst = i_rst;
    #1;
    if (do_chk) model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic idle_step(input bit do_chk);
    drv(4'b0, 0, 0, 0, 0, 0, 0, 4'b0, 0, do_chk);
    tick();
  endtask

  initial begin
    //          irq     if0 it0 it2 ies  ita  pend   ie vv vec    spur
    tbl[0]  = '{4'b0000, 0, 0, 0, 0,   0, 4'b0000, 0, 0, 8'h00, 0};
    tbl[1]  = '{4'b0100, 0, 0, 0, 0,   0, 4'b0000, 0, 0, 8'h00, 0};
    tbl[2]  = '{4'b0100, 1, 0, 0, 0,   0, 4'b0100, 0, 0, 8'h00, 0};
    tbl[3]  = '{4'b0100, 0, 0, 0, 1,   0, 4'b0100, 0, 0, 8'h00, 0};
    tbl[4]  = '{4'b0100, 1, 0, 0, 0,   1, 4'b0100, 1, 0, 8'h00, 0};
    tbl[5]  = '{4'b0100, 0, 1, 0, 0,   0, 4'b0000, 0, 1, 8'hF4, 0};
    tbl[6]  = '{4'b0100, 0, 0, 0, 0,   0, 4'b0000, 0, 1, 8'hF4, 0};
    tbl[7]  = '{4'b0100, 0, 0, 1, 0,   0, 4'b0000, 0, 1, 8'hF4, 0};
    tbl[8]  = '{4'b0000, 0, 0, 0, 1,   0, 4'b0000, 0, 0, 8'hF4, 0};
    tbl[9]  = '{4'b1010, 0, 0, 0, 0,   0, 4'b0000, 1, 0, 8'hF4, 0};
    tbl[10] = '{4'b1010, 1, 0, 0, 0,   1, 4'b1010, 1, 0, 8'hF4, 0};
    tbl[11] = '{4'b1010, 0, 1, 0, 0,   0, 4'b1000, 0, 1, 8'hF2, 0};
    tbl[12] = '{4'b1010, 0, 0, 0, 0,   0, 4'b1000, 0, 1, 8'hF2, 0};
    tbl[13] = '{4'b1010, 0, 0, 1, 0,   0, 4'b1000, 0, 1, 8'hF2, 0};
    tbl[14] = '{4'b1010, 0, 0, 0, 0,   0, 4'b1000, 0, 0, 8'hF2, 0};
    tbl[15] = '{4'b0000, 0, 1, 0, 0,   0, 4'b1000, 0, 0, 8'hF2, 0};
    tbl[16] = '{4'b0000, 0, 0, 0, 0,   0, 4'b1000, 0, 1, 8'hF8, 1};
    tbl[17] = '{4'b0000, 0, 0, 1, 0,   0, 4'b1000, 0, 1, 8'hF8, 0};
    tbl[18] = '{4'b0000, 0, 0, 0, 0,   0, 4'b1000, 0, 0, 8'hF8, 0};

    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      drv(4'b0, 0, 0, 0, 0, 0, 0, 4'b0, 1, 0);
      tick();
    end

    // Directed table: reset state, edge latch, priority grant, spurious IT0
    for (int r = 0; r < 19; r++) begin
      drv(tbl[r].irq, tbl[r].if0, tbl[r].it0, tbl[r].it2, tbl[r].ies, 0, 0, 4'b0, 0, 1);
      chk($sformatf("T%0d.ITA", r), 32'(ita), 32'(tbl[r].e_ita));
      chk($sformatf("T%0d.PEND", r), 32'(pend), 32'(tbl[r].e_pend));
      chk($sformatf("T%0d.IE", r), 32'(ie), 32'(tbl[r].e_ie));
      chk($sformatf("T%0d.VV", r), 32'(vec_valid), 32'(tbl[r].e_vv));
      chk($sformatf("T%0d.VEC", r), 32'(vector), 32'(tbl[r].e_vec));
      chk($sformatf("T%0d.SPUR", r), 32'(spurious), 32'(tbl[r].e_spur));
      tick();
    end

    // Masked pending line, MASK_WE and IE_SET in the grant cycle
    drv(4'b0, 0, 0, 0, 0, 0, 0, 4'b0, 1, 1); tick();
    drv(4'b0001, 0, 0, 0, 1, 0, 0, 4'b0, 0, 1); tick();
    drv(4'b0001, 0, 0, 0, 0, 0, 1, 4'b1110, 0, 1); tick();
    drv(4'b0001, 1, 0, 0, 0, 0, 0, 4'b0, 0, 1);
    chk("MASKED.ITA", 32'(ita), 32'(0));
    chk("MASKED.PEND", 32'(pend), 32'(4'b0001));
    tick();
    drv(4'b0001, 0, 0, 0, 0, 0, 1, 4'b1111, 0, 1); tick();
    drv(4'b0001, 1, 0, 0, 1, 0, 1, 4'b0000, 0, 1);
    chk("UNMASKED.ITA", 32'(ita), 32'(1));
    tick();
    drv(4'b0001, 0, 1, 0, 0, 0, 0, 4'b0, 0, 1);
    chk("GRANT0.VEC", 32'(vector), 32'(8'hF0));
    chk("GRANT0.IE", 32'(ie), 32'(0));
    tick();
    drv(4'b0, 0, 0, 0, 0, 0, 0, 4'b0, 0, 1); tick();
    drv(4'b0, 0, 0, 1, 0, 0, 1, 4'b1111, 0, 1); tick();

    // Re-rise on the granted line in the grant cycle
    drv(4'b0010, 0, 0, 0, 1, 0, 0, 4'b0, 0, 1); tick();
    idle_step(1);
    drv(4'b0010, 1, 0, 0, 0, 0, 0, 4'b0, 0, 1);
    chk("RERISE.ITA", 32'(ita), 32'(1));
    tick();
    drv(4'b0010, 0, 1, 0, 0, 0, 0, 4'b0, 0, 1);
    chk("RERISE.PEND", 32'(pend), 32'(4'b0010));
    chk("RERISE.VEC", 32'(vector), 32'(8'hF2));
    tick();
    drv(4'b0010, 0, 0, 0, 0, 0, 0, 4'b0, 0, 1); tick();
    drv(4'b0010, 0, 0, 1, 0, 0, 0, 4'b0, 0, 1); tick();
    drv(4'b0010, 1, 0, 0, 0, 0, 0, 4'b0, 0, 1);
    chk("SERVE_IF0.ITA", 32'(ita), 32'(0));
    tick();
    drv(4'b0010, 0, 0, 0, 1, 0, 0, 4'b0, 0, 1); tick();
    drv(4'b0010, 1, 0, 0, 0, 0, 0, 4'b0, 0, 1);
    chk("RESERVE.ITA", 32'(ita), 32'(1));
    tick();

    // Reset mid-sequence at IT1
    drv(4'b0, 0, 1, 0, 0, 0, 1, 4'b0111, 0, 1); tick();
    drv(4'b1000, 0, 0, 0, 1, 0, 0, 4'b0, 1, 1); tick();
    drv(4'b1000, 0, 0, 0, 0, 0, 0, 4'b0, 0, 1);
    chk("RST.VV", 32'(vec_valid), 32'(0));
    chk("RST.PEND", 32'(pend), 32'(0));
    chk("RST.IE", 32'(ie), 32'(0));
    tick();
    drv(4'b1000, 0, 0, 0, 1, 0, 0, 4'b0, 0, 1); tick();
    drv(4'b1000, 1, 0, 0, 0, 0, 0, 4'b0, 0, 1);
    chk("RST.MASK_ITA", 32'(ita), 32'(1));
    tick();
    drv(4'b1000, 0, 1, 0, 0, 0, 0, 4'b0, 0, 1);
    chk("RST.VEC3", 32'(vector), 32'(8'hF6));
    tick();
    drv(4'b0, 0, 0, 1, 0, 0, 0, 4'b0, 0, 1); tick();

    // Random stimulus against the model
    begin
      logic [3:0] r_irq;
      logic       r_if0, r_it0;
      r_irq = 4'b0;
      for (int n = 0; n < 600; n++) begin
        if ($urandom_range(0, 3) == 0) r_irq = 4'($urandom());
        r_if0 = ($urandom_range(0, 3) == 0);
        r_it0 = !r_if0 && ($urandom_range(0, 7) == 0);
        drv(r_irq, r_if0, r_it0, ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) == 0), 4'($urandom()),
            ($urandom_range(0, 149) == 0), 1);
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
